// File: rtl/mips_pkg.sv
// Fetch-path definitions shared by IF/ID and the instruction memory responder:
// responder state encoding, the NOP word and the word-range helper.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // True when every byte-address bit above the word index is zero.
  function automatic logic word_in_range(input logic [31:0] byte_addr,
                                         input int unsigned idx_w);
    logic [31:0] upper;
    upper = byte_addr >> (idx_w + 2);
    return (upper == 32'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: one synchronous write port, one registered
// read port; a same-cycle read of the word being written returns the old word.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory responder for the IF stage: accepts a PC, answers after a
// fixed number of wait states and holds IF/ID via stall while a fetch is in flight.
module imem_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = MIPS_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        rdy,
  output logic        err,
  output logic        stall,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  imem_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             rdy_q;
  logic             err_q;
  logic             nop_sel_q;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             fetch_ok;
  logic             load_ok;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_data;

  assign fetch_idx = IDX_W'(addr >> 2);
  assign fetch_ok  = (addr[1:0] == 2'b00) && word_in_range(addr, IDX_W);
  assign load_idx  = IDX_W'(load_addr >> 2);
  assign load_ok   = word_in_range(load_addr, IDX_W);
  assign wr_en     = load_en && !rst && load_ok;

  // With no wait states the read is issued straight from the incoming PC.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = idx_q;
    if (!rst) begin
      if ((state_q == IDLE) && req && fetch_ok && (WAIT_CYCLES == 0)) begin
        rd_en  = 1'b1;
        rd_idx = fetch_idx;
      end else if ((state_q == WAIT) && (cnt_q == CNT_W'(1))) begin
        rd_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      nop_sel_q <= 1'b1;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (!fetch_ok) begin
              state_q   <= RESP;
              rdy_q     <= 1'b1;
              err_q     <= 1'b1;
              nop_sel_q <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state_q   <= RESP;
              rdy_q     <= 1'b1;
              err_q     <= 1'b0;
              nop_sel_q <= 1'b0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= RESP;
            cnt_q     <= '0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
            nop_sel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The latched index is datapath only; later addr changes are ignored.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req) idx_q <= fetch_idx;
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (load_idx),
    .wr_data_i (load_data),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  assign inst  = nop_sel_q ? NOP_INST : rd_data;
  assign rdy   = rdy_q;
  assign err   = err_q;
  assign stall = !rst && (((state_q == IDLE) && req) || (state_q == WAIT));

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: two instances (2 wait states and 0 wait states) share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_imem_ctrl;
  import mips_pkg::*;

  localparam int DEPTH = 256;
  localparam int IW    = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] load_addr = 32'd0;
  logic [31:0] load_data = 32'd0;

  logic [31:0] inst2, inst0;
  logic        rdy2, rdy0, err2, err0, stall2, stall0;

  imem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .NOP_INST(32'h0)) u2 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .inst(inst2), .rdy(rdy2),
    .err(err2), .stall(stall2), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data));

  imem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .NOP_INST(32'h0)) u0 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .inst(inst0), .rdy(rdy0),
    .err(err0), .stall(stall0), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each instance has at most one outstanding fetch with a
  // known response edge; the next request can be taken two edges later.
  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          wc      [2] = '{2, 0};
  int          idle_at [2] = '{0, 0};
  int          resp_at [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  bit          p_bad   [2] = '{0, 0};
  logic [31:0] p_addr  [2];
  logic [31:0] e_inst  [2];
  bit          e_rdy   [2] = '{0, 0};
  bit          e_err   [2] = '{0, 0};
  bit          mvalid = 0;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      e_rdy[d] = 1'b0;
      if (rst) begin
        pend[d]    = 1'b0;
        idle_at[d] = cyc + 1;
        e_inst[d]  = 32'h0;
        e_err[d]   = 1'b0;
      end else begin
        if (!pend[d] && cyc >= idle_at[d] && req) begin
          pend[d]    = 1'b1;
          p_addr[d]  = addr;
          p_bad[d]   = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
          resp_at[d] = p_bad[d] ? cyc : cyc + wc[d];
          idle_at[d] = resp_at[d] + 2;
        end
        if (pend[d] && resp_at[d] == cyc) begin
          e_rdy[d]  = 1'b1;
          e_err[d]  = p_bad[d];
          e_inst[d] = p_bad[d] ? 32'h0 : mem[p_addr[d][IW+1:2]];
          pend[d]   = 1'b0;
        end
      end
    end
    // Applied after the reads above: same-edge read sees the old word.
    if (!rst && load_en && load_addr < 32'(DEPTH * 4)) mem[load_addr[IW+1:2]] = load_data;
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] ai;
        logic        ar, ae, as, es;
        if (d == 0) begin ai = inst2; ar = rdy2; ae = err2; as = stall2; end
        else        begin ai = inst0; ar = rdy0; ae = err0; as = stall0; end
        es = !rst && ((pend[d] && !p_bad[d] && cyc < resp_at[d]) ||
                      (!pend[d] && cyc + 1 >= idle_at[d] && req));
        chk(d == 0 ? "w2_rdy"   : "w0_rdy",   {31'b0, ar}, {31'b0, e_rdy[d]});
        chk(d == 0 ? "w2_err"   : "w0_err",   {31'b0, ae}, {31'b0, e_err[d]});
        chk(d == 0 ? "w2_inst"  : "w0_inst",  ai, e_inst[d]);
        chk(d == 0 ? "w2_stall" : "w0_stall", {31'b0, as}, {31'b0, es});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold req until the selected instance responds, then release and drain.
  task automatic fetch(input logic [31:0] a, input bit sel0, output int nst,
                       output logic [31:0] ri, output logic re);
    bit got;
    got = 1'b0;
    nst = 0;
    ri  = 32'hxxxx_xxxx;
    re  = 1'bx;
    req  = 1'b1;
    addr = a;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if ((sel0 ? stall0 : stall2) === 1'b1) nst++;
      if ((sel0 ? rdy0 : rdy2) === 1'b1) begin
        got = 1'b1;
        ri  = sel0 ? inst0 : inst2;
        re  = sel0 ? err0 : err2;
      end
    end
    chk("fetch_done", {31'b0, got}, 32'd1);
    tick();
    req = 1'b0;
    repeat (4) tick();
  endtask

  int          nst;
  logic [31:0] ri;
  logic        re;
  bit          got;
  int          first_rdy, second_rdy, nrdy;

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_inst", inst2, 32'h0);
    chk("reset_stall", {31'b0, stall2}, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 4) ? 32'h2008_0005 : $urandom;
      tick();
    end
    load_en = 1'b0;
    tick();

    fetch(32'h10, 1'b0, nst, ri, re);
    chk("good_inst", ri, 32'h2008_0005);
    chk("good_err", {31'b0, re}, 32'd0);
    chk("good_stall_cycles", 32'(nst), 32'd3);

    fetch(32'h13, 1'b0, nst, ri, re);
    chk("misaligned_inst", ri, 32'h0);
    chk("misaligned_err", {31'b0, re}, 32'd1);
    chk("misaligned_stall_cycles", 32'(nst), 32'd1);

    fetch(32'h400, 1'b0, nst, ri, re);
    chk("range_inst", ri, 32'h0);
    chk("range_err", {31'b0, re}, 32'd1);

    fetch(32'h10, 1'b1, nst, ri, re);
    chk("w0_inst_lit", ri, 32'h2008_0005);
    chk("w0_stall_cycles", 32'(nst), 32'd1);

    // Request dropped right after acceptance, addr moved to a bad PC.
    req = 1'b1; addr = 32'h10;
    tick();
    req = 1'b0; addr = 32'h13;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (rdy2 === 1'b1) begin
        got = 1'b1;
        chk("drop_inst", inst2, 32'h2008_0005);
        chk("drop_err", {31'b0, err2}, 32'd0);
      end
    end
    chk("drop_done", {31'b0, got}, 32'd1);
    repeat (4) tick();

    // Continuous request: responses every WAIT_CYCLES+2 cycles.
    req = 1'b1; addr = 32'h10;
    first_rdy = -1; second_rdy = -1; nrdy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rdy2 === 1'b1) begin
        nrdy++;
        if (first_rdy < 0) first_rdy = k;
        else if (second_rdy < 0) second_rdy = k;
      end
    end
    chk("b2b_count", 32'(nrdy), 32'd3);
    chk("b2b_gap", 32'(second_rdy - first_rdy), 32'd4);
    tick();
    req = 1'b0;
    repeat (5) tick();

    // Load of word 4 lands on the same edge as the read of word 4.
    req = 1'b1; addr = 32'h10;
    tick();
    req = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    @(negedge clk);
    chk("rbw_rdy", {31'b0, rdy2}, 32'd1);
    chk("rbw_old", inst2, 32'h2008_0005);
    repeat (4) tick();
    fetch(32'h10, 1'b0, nst, ri, re);
    chk("rbw_new", ri, 32'hDEAD_BEEF);

    // Reset during the second wait cycle discards the fetch.
    req = 1'b1; addr = 32'h10;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_inst", inst2, 32'h0);
    chk("rst_mid_stall", {31'b0, stall2}, 32'd0);
    nrdy = (rdy2 === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy2 === 1'b1) nrdy++;
    end
    chk("rst_mid_no_rdy", 32'(nrdy), 32'd0);
    tick();
    fetch(32'h10, 1'b0, nst, ri, re);
    chk("after_rst_inst", ri, 32'hDEAD_BEEF);

    // Random traffic: requests, preloads, occasional resets.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      req = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
        2:       addr = 32'h400 + ($urandom_range(0, 15) << 2);
        default: addr = $urandom_range(0, 255) << 2;
      endcase
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 1023));
      load_data = $urandom;
      tick();
    end
    rst = 1'b0; req = 1'b0; load_en = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
